vote_decrypt_sched: RTL
=======================

# vote_decrypt_sched

Round-robin scheduler that shares one Gray-to-binary decryption datapath between up to eight requesters, such as the tally display, the audit port and the result serializer. It grants one requester at a time, captures its Gray-coded vote word, and decodes it through a single decryption instance. It then presents the binary result with the requester ID on a valid/ready output port. The block sits between the encrypted vote-count storage readers and every consumer of plaintext counts.

## Interface
- N_REQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(N_REQ), width of out_id (derived; do not override)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request; held high with data stable until matching ack
- gray_in  in  8*N_REQ  Gray-coded word; requester i on bits [8*i+7:8*i]
- par_in  in  N_REQ  per-requester parity bit, equal to XOR of that requester's 8 Gray bits
- ack  out  N_REQ  one-hot, one-cycle pulse; the data for that requester has been captured
- out_valid  out  1  out_bin, out_id and out_err are valid
- out_ready  in  1  consumer accepts the output
- out_id  out  IDW  index of the requester that owns out_bin
- out_bin  out  8  decrypted binary word
- out_err  out  1  parity mismatch on the captured word
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, CAPT, VALID.
- IDLE, no req: stay in IDLE.
- IDLE, any req: select the winner, capture gray_in and par_in of the winner into internal registers, register ack[winner]=1, move to CAPT.
- Winner selection: first asserted req searching upward from last+1 modulo N_REQ, where last is the most recently granted ID.
- CAPT: register out_bin = decrypt(captured word), out_id = winner, out_err (see Configuration), out_valid=1. Update last = winner. Move to VALID.
- VALID: hold all outputs stable. When out_valid && out_ready, clear out_valid and move to IDLE.
- Decryption is bitwise prefix XOR: bin[7]=G[7], and bin[k]=bin[k+1]^G[k] for k=6..0. It is done through one shared combinational decryption instance fed by the captured register.
- Only one word is in flight at a time. Requests arriving in CAPT or VALID wait; they are never lost while req stays high.
- A requester that drops req before ack is simply not served. No error is flagged.

## Timing
- Reset values:
  - state=IDLE, ack=0, out_valid=0, out_id=0, out_bin=0x00, out_err=0, busy=0.
  - last=N_REQ-1, so requester 0 wins first.
- Grant at edge k: ack high during cycle k..k+1, then 0. Requesters may drop req or change data from edge k+1.
- out_valid rises at edge k+1, which gives a grant-to-valid latency of 1 cycle.
- If out_ready is already high, the handshake completes at edge k+2 and the next grant can occur at edge k+3. Peak throughput is one word per 3 cycles.
- If out_ready is low, VALID holds indefinitely with outputs frozen.
- Back-to-back requests from all requesters are served in strict rotation 0,1,2,…; no requester waits more than N_REQ grants.
- If rst is asserted in any state, the next edge applies the reset values. Any captured or pending word is discarded and no ack is issued on that edge.
- rst and req together: reset wins.

## Configuration
- DECRYPT_PARITY_EN defined:
  - In CAPT, out_err = XOR(captured Gray bits) ^ captured par_in.
  - The word is still decoded and delivered; the consumer decides whether to discard it.
- DECRYPT_PARITY_EN undefined:
  - par_in is ignored and no parity logic is built.
  - out_err is tied to 0.

## Test plan
- Reset, then a single req[0] with gray 0x0C and par 0: ack[0] is a one-cycle pulse. One cycle later out_valid=1, out_bin=0x08, out_id=0, out_err=0.
- req[2] with 0xFF and par 0: out_bin=0xAA, out_id=2. Hold out_ready=0 for 5 cycles: outputs stay stable and busy=1 throughout.
- All four req held with words 0x80, 0x01, 0x03, 0x00 and out_ready=1:
  - Outputs come in order id 0,1,2,3 with out_bin 0xFF, 0x01, 0x02, 0x00.
  - Each output is 3 cycles apart.
  - Exactly one ack per requester.
- Fairness: served id 1, then req[0] and req[3] asserted together: id 3 is served before id 0.
- rst asserted during VALID (out_bin=0xFF pending): next edge gives out_valid=0, out_bin=0x00, busy=0, and requester 0 holds top priority.
- With DECRYPT_PARITY_EN, gray 0x0C with par 1: out_err=1 and out_bin=0x08. Without the macro: out_err=0.

Source files
------------

// File: rtl/vote_decrypt_sched.sv
// vote_decrypt_sched: round-robin scheduler that shares one Gray-to-binary
// decryption datapath between up to eight requesters. One word is in flight
// at a time: grant/capture, decode, then hold on a valid/ready output port.
//
// Optional feature macro: DECRYPT_PARITY_EN
//   defined   -> per-requester parity is captured and checked, result on out_err
//   undefined -> par_in is ignored, no parity logic is built, out_err is 0
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing in flight; arbitrate and capture the winner's word
// ST_CAPT  | captured word is decoded and loaded into the output registers
// ST_VALID | output presented; wait for out_ready, then return to idle

// Shared combinational decryption: bin[k] is the XOR of Gray bits 7..k.
module vote_gray2bin (
  input  logic [7:0] gray,
  output logic [7:0] bin
);

  // running XOR from the MSB down to each bit position
  always_comb begin
    logic acc;
    bin = '0;
    acc = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      acc    = acc ^ gray[k];
      bin[k] = acc;
    end
  end

endmodule

module vote_decrypt_sched #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] gray_in,
  input  logic [N_REQ-1:0]   par_in,
  output logic [N_REQ-1:0]   ack,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDW-1:0]     out_id,
  output logic [7:0]         out_bin,
  output logic               out_err,
  output logic               busy
);

  // one extra bit so last+1+offset never wraps before the modulo step
  localparam int SW = IDW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [7:0]       cap_word_q, cap_word_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             out_valid_q, out_valid_d;
  logic [IDW-1:0]   out_id_q, out_id_d;
  logic [7:0]       out_bin_q, out_bin_d;

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] scan;
  logic [SW-1:0]    rot_sh;
  logic [SW-1:0]    off;
  logic [SW-1:0]    sum;
  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [N_REQ-1:0] grant_onehot;
  logic [7:0]       dec_bin;

  // round-robin pick: rotate req so bit 0 is last+1, take the first set bit
  always_comb begin
    rot_sh      = {1'b0, last_q} + SW'(1);
    rot         = N_REQ'({req, req} >> rot_sh);
    scan        = rot;
    grant_found = 1'b0;
    off         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && scan[0]) begin
        grant_found = 1'b1;
        off         = SW'(i);
      end
      scan = scan >> 1;
    end
    sum = rot_sh + off;
    if (sum >= SW'(N_REQ)) begin
      sum = sum - SW'(N_REQ);
    end
    grant_id     = sum[IDW-1:0];
    grant_onehot = N_REQ'(1) << grant_id;
  end

  vote_gray2bin u_dec (
    .gray (cap_word_q),
    .bin  (dec_bin)
  );

  // next-state and next register values; everything holds unless changed
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    cap_word_d  = cap_word_q;
    ack_d       = '0;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_bin_d   = out_bin_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d    = ST_CAPT;
          ack_d      = grant_onehot;
          win_d      = grant_id;
          cap_word_d = 8'(gray_in >> {grant_id, 3'b000});
        end
      end
      ST_CAPT: begin
        out_bin_d   = dec_bin;
        out_id_d    = win_q;
        out_valid_d = 1'b1;
        last_d      = win_q;
        state_d     = ST_VALID;
      end
      ST_VALID: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // state and datapath registers; reset discards any word in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= IDW'(N_REQ - 1);
      win_q       <= '0;
      cap_word_q  <= '0;
      ack_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_bin_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      cap_word_q  <= cap_word_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_bin_q   <= out_bin_d;
    end
  end

`ifdef DECRYPT_PARITY_EN
  logic cap_par_q;
  logic out_err_q;

  // capture the winner's parity with its word, check it while decoding
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_par_q <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && grant_found) begin
        cap_par_q <= |(par_in & grant_onehot);
      end
      if (state_q == ST_CAPT) begin
        out_err_q <= (^cap_word_q) ^ cap_par_q;
      end
    end
  end

  assign out_err = out_err_q;
`else
  logic unused_par;
  assign unused_par = ^par_in;
  assign out_err    = 1'b0;
`endif

  assign ack       = ack_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_bin   = out_bin_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
